// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the cascaded BCD timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Saturate an out-of-range nibble to the largest BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD up/down digit with synchronous load and a carry/borrow-out flag.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] q,
  output logic       cop
);

  logic [3:0] q_q, q_d;

  // Next digit value: load wins, otherwise step in the given direction.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      if (dir == DIR_UP) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else               q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign cop = (dir == DIR_UP) ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run controller: command FSM, prescaler, direction latch and preset clamp
// driving a chain of bcd_digit counters.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic                  sta,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   num,
  output logic                  running,
  output logic                  done,
  output logic [1:0]            st
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 dir_q, dir_d;
  logic                 done_q, done_d;
  logic                 load_en, step, tick, term, near_term, upper_cop;
  logic [DIGITS-1:0]    en, cop;
  logic [4*DIGITS-1:0]  num_w, preset_c;

  // Clamp every preset nibble to a legal BCD digit.
  always_comb begin
    preset_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      preset_c[4*i +: 4] = bcd_clamp(preset[4*i +: 4]);
  end

  // Terminal detection: term = already at the end; near_term = one step away,
  // so DONE and the final count update land on the same edge.
  always_comb begin
    upper_cop = 1'b1;
    for (int unsigned i = 1; i < DIGITS; i++) upper_cop = upper_cop & cop[i];
    term      = &cop;
    near_term = upper_cop &
                ((dir_q == DIR_UP) ? (num_w[3:0] == BCD_MAX - 4'd1)
                                   : (num_w[3:0] == BCD_MIN + 4'd1));
  end

  // Ripple enable chain: digit i steps only when all lower digits carry/borrow.
  always_comb begin
    logic acc;
    acc = step;
    en  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      en[i] = acc;
      acc   = acc & cop[i];
    end
  end

  // Command FSM with priority stop > load > start, plus prescaler and direction.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    load_en = 1'b0;
    step    = 1'b0;
    tick    = (presc_q == PS_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          // load and start together in IDLE both take effect
          if (load) load_en = 1'b1;
          if (start) begin
            dir_d   = sta;
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) state_d = ST_IDLE;
        else if (load) load_en = 1'b1;
        else if (start) begin
          dir_d   = sta;
          presc_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) state_d = ST_IDLE;
        else if (load) begin
          load_en = 1'b1;
          state_d = ST_IDLE;
        end else if (start) begin
          load_en = 1'b1;
          dir_d   = sta;
          presc_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (term) begin
            state_d = ST_DONE;
          end else begin
            step = 1'b1;
            if (near_term) state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_en),
      .d     (preset_c[4*g +: 4]),
      .en    (en[g]),
      .dir   (dir_q),
      .q     (num_w[4*g +: 4]),
      .cop   (cop[g])
    );
  end

  assign num     = num_w;
  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign st      = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl against a decimal-integer reference model.
module tb_bcd_timer_ctrl;

  localparam int D = 2;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, stop = 1'b0, load = 1'b0, sta = 1'b0;
  logic [4*D-1:0] preset = '0;
  logic [4*D-1:0] num;
  logic           running, done;
  logic [1:0]     st;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Reference model state: plain decimal value and state number 0..3.
  int m_state = 0, m_cnt = 0, m_dir = 0, m_presc = 0, m_done = 0;

  bcd_timer_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .sta(sta), .preset(preset), .num(num), .running(running),
    .done(done), .st(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int max_val();
    int v = 1;
    for (int i = 0; i < D; i++) v = v * 10;
    return v - 1;
  endfunction

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < D; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [4*D-1:0] p);
    int v = 0, w = 1, dg;
    for (int i = 0; i < D; i++) begin
      dg = int'(p[4*i +: 4]);
      if (dg > 9) dg = 9;
      v = v + dg * w;
      w = w * 10;
    end
    return v;
  endfunction

  // One clock of the behavioural model, given this cycle's commands.
  task automatic model_step();
    int term;
    term   = (m_dir != 0) ? 0 : max_val();
    m_done = 0;
    case (m_state)
      0: if (!stop) begin
           if (load) m_cnt = clamp_val(preset);
           if (start) begin m_dir = sta; m_presc = 0; m_state = 1; end
         end
      2: if (stop) m_state = 0;
         else if (load) m_cnt = clamp_val(preset);
         else if (start) begin m_dir = sta; m_presc = 0; m_state = 1; end
      3: if (stop) m_state = 0;
         else if (load) begin m_cnt = clamp_val(preset); m_state = 0; end
         else if (start) begin
           m_cnt = clamp_val(preset); m_dir = sta; m_presc = 0; m_state = 1;
         end
      default: if (stop) m_state = 2;
         else if (m_presc == P - 1) begin
           m_presc = 0;
           if (m_cnt == term) begin m_state = 3; m_done = 1; end
           else begin
             m_cnt = m_cnt + ((m_dir != 0) ? -1 : 1);
             if (m_cnt == term) begin m_state = 3; m_done = 1; end
           end
         end else m_presc++;
    endcase
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_dir = 0; m_presc = 0; m_done = 0;
  endtask

  // Drive one cycle of commands, step the model, then compare after the edge.
  task automatic cyc(input logic s_start, input logic s_stop, input logic s_load,
                     input logic s_sta, input logic [4*D-1:0] s_preset);
    @(negedge clk);
    start = s_start; stop = s_stop; load = s_load; sta = s_sta; preset = s_preset;
    model_step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
    check("num", int'(num), to_bcd(m_cnt));
    check("st", int'(st), m_state);
    check("running", int'(running), int'(m_state == 1));
    check("done", int'(done), m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, sta, preset);
  endtask

  task automatic wait_state(input string tag, input int target, input int bound);
    int k = 0;
    while (int'(st) != target && k < bound) begin
      idle(1);
      k++;
    end
    check(tag, int'(st), target);
  endtask

  initial begin
    int k;
    #12;
    check("rst_num", int'(num), 0);
    check("rst_st", int'(st), 0);
    check("rst_done", int'(done), 0);
    check("rst_running", int'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up from 07: first change 4 cycles after start, ripple, done at 99.
    cyc(0, 0, 1, 0, 8'h07);
    cyc(1, 0, 0, 0, 8'h07);
    idle(3);
    check("up_before_tick", int'(num), 8'h07);
    idle(1);
    check("up_first", int'(num), 8'h08);
    idle(8);
    check("up_ripple", int'(num), 8'h10);
    done_seen = 0;
    wait_state("up_reach_done", 3, 500);
    check("up_num99", int'(num), 8'h99);
    idle(10);
    check("up_done_once", done_seen, 1);

    // Count down from 12 to 00, no wrap.
    cyc(0, 0, 1, 0, 8'h12);
    cyc(1, 0, 0, 1, 8'h12);
    wait_state("dn_reach_done", 3, 200);
    check("dn_num00", int'(num), 8'h00);
    idle(12);

    // Pause at 05, hold, resume, stop twice.
    cyc(0, 0, 1, 0, 8'h04);
    cyc(1, 0, 0, 0, 8'h04);
    k = 0;
    while (num != 8'h05 && k < 20) begin idle(1); k++; end
    check("reach05", int'(num), 8'h05);
    cyc(0, 1, 0, 0, 8'h04);
    check("pause_st", int'(st), 2);
    idle(20);
    check("pause_hold", int'(num), 8'h05);
    cyc(1, 0, 0, 0, 8'h04);
    idle(4);
    check("resume06", int'(num), 8'h06);
    cyc(0, 1, 0, 0, 8'h04);
    cyc(0, 1, 0, 0, 8'h04);
    check("stop2_idle", int'(st), 0);

    // Clamp, load ignored in RUN, stop+start in PAUSE.
    cyc(0, 0, 1, 0, 8'hAF);
    check("clamp99", int'(num), 8'h99);
    cyc(1, 0, 0, 1, 8'hAF);
    cyc(0, 0, 1, 0, 8'h11);
    idle(2);
    cyc(0, 1, 0, 0, 8'h11);
    cyc(1, 1, 0, 0, 8'h11);
    check("stop_start_idle", int'(st), 0);

    // Start at terminal value, then restart from DONE.
    cyc(0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);
    idle(4);
    check("term_start_done", int'(st), 3);
    check("term_start_num", int'(num), 8'h00);
    cyc(1, 0, 0, 0, 8'h35);
    check("done_reload", int'(num), 8'h35);

    // Asynchronous reset in the middle of a tick period.
    idle(6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 0; stop = 0; load = 0;
    #1;
    check("arst_num", int'(num), 0);
    check("arst_st", int'(st), 0);
    check("arst_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 8'h00);
    idle(3);
    check("post_rst_hold", int'(num), 8'h00);
    idle(1);
    check("post_rst_tick", int'(num), 8'h01);

    // Randomized command traffic.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(15) == 0), ($urandom_range(50) == 0),
          ($urandom_range(25) == 0), 1'($urandom_range(1)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
